pipelined_adder: RTL and testbench

- Parametrised, pipelined successor to the team's fixed-width ripple-carry adders.
- Splits a WIDTH-bit add/subtract into STAGES carry-chain segments, with a carry register between segments.
- Uses a valid/ready handshake, so it drops into datapaths that need higher clock rates than one long ripple chain allows.
- Output is WIDTH+1 bits; the MSB is the final carry-out.

---
 rtl/pipelined_adder.sv | 111 +++++++++++
 tb/tb_pipelined_adder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// ============================================================================
// pipelined_adder : WIDTH-bit add/subtract split into STAGES carry segments
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_adder #(
  parameter int WIDTH  = 26,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int c_SEG = (WIDTH + STAGES - 1) / STAGES;

  logic             w_en;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin0;

  logic [WIDTH-1:0] w_a_in  [STAGES];
  logic [WIDTH-1:0] w_b_in  [STAGES];
  logic [WIDTH-1:0] w_s_in  [STAGES];
  logic [WIDTH-1:0] w_s_nxt [STAGES];
  logic             w_c_in  [STAGES];
  logic             w_c_nxt [STAGES];
  logic             w_v_in  [STAGES];

  // r_a/r_b carry the not-yet-added upper slices; r_s holds finished low slices
  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic             r_c [STAGES];
  logic             r_v [STAGES];

  assign w_b_eff = sub ? ~b : b;
  assign w_cin0  = sub | c_in;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int c_LO = k * c_SEG;

      if (k == 0) begin : g_first
        assign w_a_in[k] = a;
        assign w_b_in[k] = w_b_eff;
        assign w_s_in[k] = '0;
        assign w_c_in[k] = w_cin0;
        assign w_v_in[k] = in_valid;
      end else begin : g_next
        assign w_a_in[k] = r_a[k-1];
        assign w_b_in[k] = r_b[k-1];
        assign w_s_in[k] = r_s[k-1];
        assign w_c_in[k] = r_c[k-1];
        assign w_v_in[k] = r_v[k-1];
      end

      if (c_LO < WIDTH) begin : g_seg
        localparam int               c_SW   = (WIDTH - c_LO < c_SEG) ? (WIDTH - c_LO) : c_SEG;
        localparam logic [WIDTH-1:0] c_MASK = WIDTH'({c_SW{1'b1}}) << c_LO;
        logic [c_SW:0] w_seg;

        assign w_seg = {1'b0, c_SW'(w_a_in[k] >> c_LO)}
                     + {1'b0, c_SW'(w_b_in[k] >> c_LO)}
                     + (c_SW + 1)'(w_c_in[k]);
        assign w_s_nxt[k] = (w_s_in[k] & ~c_MASK) | (WIDTH'(w_seg[c_SW-1:0]) << c_LO);
        assign w_c_nxt[k] = w_seg[c_SW];
      end else begin : g_pass
        // Trailing empty segment when ceil() over-allocates: carry just moves on
        assign w_s_nxt[k] = w_s_in[k];
        assign w_c_nxt[k] = w_c_in[k];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
        r_v[k] <= 1'b0;
      end
    end else if (w_en) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= w_a_in[k];
        r_b[k] <= w_b_in[k];
        r_s[k] <= w_s_nxt[k];
        r_c[k] <= w_c_nxt[k];
        r_v[k] <= w_v_in[k];
      end
    end
  end

  assign w_en      = !r_v[STAGES-1] | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v[STAGES-1];
  assign sum       = {r_c[STAGES-1], r_s[STAGES-1]};

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder.sv
// ============================================================================
// tb_pipelined_adder : directed + scoreboard bench for two adder configurations
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [25:0] a0 = '0;
  logic [25:0] b0 = '0;
  logic        c_in = 1'b0;
  logic        sub = 1'b0;

  logic        in_ready0, out_valid0;
  logic [26:0] sum0;
  logic        in_ready1, out_valid1;
  logic [8:0]  sum1;

  int total = 0;
  int bad   = 0;

  logic [26:0] q0[$];
  logic [8:0]  q1[$];
  logic        hold0, hold1;
  logic [26:0] hsum0;
  logic [8:0]  hsum1;
  int          acc0, got0, acc1, got1, first0, last0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(26), .STAGES(2)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a0), .b(b0), .c_in(c_in), .sub(sub),
    .out_valid(out_valid0), .out_ready(out_ready), .sum(sum0)
  );

  // Uneven segments (3,3,2) exercise the remainder slice
  pipelined_adder #(.WIDTH(8), .STAGES(3)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a0[7:0]), .b(b0[7:0]), .c_in(c_in), .sub(sub),
    .out_valid(out_valid1), .out_ready(out_ready), .sum(sum1)
  );

  function automatic logic [63:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                        input logic ci, input logic sb);
    logic [63:0] m, r;
    m = (64'd1 << w) - 64'd1;
    if (sb) r = (x & m) + (~y & m) + 64'd1;
    else    r = (x & m) + (y & m) + {63'd0, ci};
    return r & ((64'd1 << (w + 1)) - 64'd1);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated op: checks latency of both instances and the DUT0 result
  task automatic send_one(input string tag, input logic [25:0] xa, input logic [25:0] xb,
                          input logic ci, input logic sb, input logic [26:0] exp0);
    logic [8:0] exp1;
    exp1 = 9'(model(8, 64'(xa), 64'(xb), ci, sb));
    out_ready = 1'b1;
    in_valid = 1'b1; a0 = xa; b0 = xb; c_in = ci; sub = sb;
    step();
    in_valid = 1'b0; a0 = '0; b0 = '0;
    check({tag, "_lat0_early"}, out_valid0, 1'b0);
    step();
    check({tag, "_valid0"}, out_valid0, 1'b1);
    check({tag, "_sum0"}, sum0, exp0);
    check({tag, "_lat1_early"}, out_valid1, 1'b0);
    step();
    check({tag, "_valid1"}, out_valid1, 1'b1);
    check({tag, "_sum1"}, sum1, exp1);
    check({tag, "_nodup0"}, out_valid0, 1'b0);
    step();
  endtask

  // mode 0: streaming, 1: 4-cycle backpressure, 2: random handshakes + reset pulse
  task automatic run(input string tag, input int nin, input int ncyc, input int mode);
    q0.delete(); q1.delete();
    hold0 = 1'b0; hold1 = 1'b0;
    acc0 = 0; got0 = 0; acc1 = 0; got1 = 0; first0 = -1; last0 = -1;
    for (int i = 0; i < ncyc; i++) begin
      rst = (mode == 2) && (i == nin / 2);
      if (i >= nin) begin
        in_valid = 1'b0; out_ready = 1'b1;
      end else begin
        in_valid  = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        out_ready = (mode == 0) ? 1'b1 :
                    (mode == 1) ? !(i >= 3 && i < 7) : ($urandom_range(0, 3) != 0);
      end
      a0 = ($urandom_range(0, 7) == 0) ? '1 : 26'($urandom);
      b0 = ($urandom_range(0, 7) == 0) ? '0 : 26'($urandom);
      c_in = 1'($urandom);
      sub  = (mode == 0) ? 1'b0 : 1'($urandom);
      #1;
      if (!rst) begin
        if (hold0) begin
          check({tag, "_stall_valid0"}, out_valid0, 1'b1);
          check({tag, "_stall_sum0"}, sum0, hsum0);
        end
        if (hold1) begin
          check({tag, "_stall_valid1"}, out_valid1, 1'b1);
          check({tag, "_stall_sum1"}, sum1, hsum1);
        end
        if (out_valid0 && !out_ready) check({tag, "_in_ready0_low"}, in_ready0, 1'b0);
        if (out_valid0 && out_ready) begin
          if (q0.size() == 0) check({tag, "_spurious0"}, out_valid0, 1'b0);
          else check({tag, "_data0"}, sum0, q0.pop_front());
          got0++;
          if (first0 < 0) first0 = i;
          last0 = i;
        end
        if (out_valid1 && out_ready) begin
          if (q1.size() == 0) check({tag, "_spurious1"}, out_valid1, 1'b0);
          else check({tag, "_data1"}, sum1, q1.pop_front());
          got1++;
        end
        if (in_valid && in_ready0) begin
          q0.push_back(27'(model(26, 64'(a0), 64'(b0), c_in, sub)));
          acc0++;
        end
        if (in_valid && in_ready1) begin
          q1.push_back(9'(model(8, 64'(a0[7:0]), 64'(b0[7:0]), c_in, sub)));
          acc1++;
        end
        hold0 = out_valid0 && !out_ready; hsum0 = sum0;
        hold1 = out_valid1 && !out_ready; hsum1 = sum1;
      end
      step();
      if (rst) begin
        check({tag, "_flush0"}, out_valid0, 1'b0);
        check({tag, "_flush1"}, out_valid1, 1'b0);
        q0.delete(); q1.delete();
        hold0 = 1'b0; hold1 = 1'b0;
        rst = 1'b0;
      end
    end
    check({tag, "_drain0"}, 64'(q0.size()), 64'd0);
    check({tag, "_drain1"}, 64'(q1.size()), 64'd0);
    if (mode == 0) begin
      check({tag, "_acc0"}, 64'(acc0), 64'(nin));
      check({tag, "_got0"}, 64'(got0), 64'(nin));
      check({tag, "_got1"}, 64'(got1), 64'(nin));
      check({tag, "_consecutive0"}, 64'(last0 - first0), 64'(nin - 1));
    end
  endtask

  initial begin
    // Reset held for 3 cycles with operands presented
    rst = 1'b1; in_valid = 1'b1; a0 = 26'h3FFFFFF; b0 = 26'h1; c_in = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_valid0", out_valid0, 1'b0);
      check("rst_sum0", sum0, 27'h0);
      check("rst_sum1", sum1, 9'h0);
    end
    rst = 1'b0; in_valid = 1'b0;
    step();
    check("post_rst_ready0", in_ready0, 1'b1);
    check("post_rst_ready1", in_ready1, 1'b1);
    check("post_rst_valid0", out_valid0, 1'b0);
    step(); step();
    check("post_rst_noemit0", out_valid0, 1'b0);
    check("post_rst_noemit1", out_valid1, 1'b0);

    send_one("add_carry_chain", 26'h3FFFFFF, 26'h0,       1'b1, 1'b0, 27'h4000000);
    send_one("add_alt",         26'h2AAAAAA, 26'h1555555, 1'b0, 1'b0, 27'h3FFFFFF);
    send_one("add_max",         26'h3FFFFFF, 26'h3FFFFFF, 1'b1, 1'b0, 27'h7FFFFFF);
    send_one("sub_neg",         26'd100,     26'd101,     1'b0, 1'b1, 27'h3FFFFFF);
    send_one("sub_eq",          26'd5,       26'd5,       1'b1, 1'b1, 27'h4000000);
    send_one("sub_zero_minus",  26'd0,       26'd1,       1'b1, 1'b1, 27'h3FFFFFF);

    run("b2b",   20,   23,   0);
    run("bp",    10,   24,   1);
    run("rand",  1000, 1030, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
